// File: rtl/key_event_scanner_pkg.sv
// Shared definitions for the keyboard front end: event field layout, scan FSM
// states and small helpers used for sizing and event packing.
package key_event_scanner_pkg;

    localparam int EV_TYPE_BIT = 7;
    localparam int EV_DIR_BIT  = 6;
    localparam int EV_IDX_W    = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic logic [7:0] make_event(input logic is_enc, input logic flag,
                                              input logic [EV_IDX_W-1:0] idx);
        logic [7:0] ev;
        ev                 = '0;
        ev[EV_TYPE_BIT]    = is_enc;
        ev[EV_DIR_BIT]     = flag;
        ev[EV_IDX_W-1:0]   = idx;
        return ev;
    endfunction

endpackage

// File: rtl/key_event_scanner_event_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra bit so
// full and empty are distinguishable after wrap-around.
module event_fifo
    import key_event_scanner_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    input  logic                    clr,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr_q - rptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & (~full | do_pop) & ~clr;
    assign dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/key_event_scanner.sv
// Key/encoder front end: synchronises raw inputs, debounces one channel per
// clock during a scan pass, and queues key/encoder event codes in a FIFO.
module key_event_scanner
    import key_event_scanner_pkg::*;
#(
    parameter int KEY_N       = 32,
    parameter int ENC_N       = 4,
    parameter int KEY_ACT_LOW = 1,
    parameter int DEB_TICKS   = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int EVENT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scanTick,
    input  logic [KEY_N-1:0]              keys,
    input  logic [ENC_N-1:0]              encA,
    input  logic [ENC_N-1:0]              encB,
    input  logic                          evRead,
    input  logic                          fifoClr,
    output logic [EVENT_W-1:0]            evData,
    output logic                          evValid,
    output logic [clog2(FIFO_DEPTH):0]    evCount,
    output logic                          overflow,
    output logic                          scanBusy
);

    localparam int                CH_N      = KEY_N + 2 * ENC_N;
    localparam int                PTR_W     = clog2(CH_N);
    localparam logic [PTR_W-1:0]  LAST_CH   = PTR_W'(CH_N - 1);
    localparam logic [PTR_W-1:0]  FIRST_ENC = PTR_W'(KEY_N);
    localparam logic [3:0]        DEB_LIMIT = 4'(DEB_TICKS);

    logic [KEY_N-1:0] keys_s1_q, keys_s2_q;
    logic [ENC_N-1:0] enca_s1_q, enca_s2_q;
    logic [ENC_N-1:0] encb_s1_q, encb_s2_q;
    logic [CH_N-1:0]  ch_sample;

    scan_state_e      state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             scan_active;

    logic [CH_N-1:0]  deb_q;
    logic [3:0]       cnt_q [CH_N];
    logic             deb_bit_d;
    logic [3:0]       cnt_d;
    logic             changed;

    logic [PTR_W-1:0] enc_off;
    logic             is_key;
    logic             b_dbn;
    logic             ev_push;
    logic [7:0]       ev_code;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            keys_s1_q <= '0;
            keys_s2_q <= '0;
            enca_s1_q <= '0;
            enca_s2_q <= '0;
            encb_s1_q <= '0;
            encb_s2_q <= '0;
        end else begin
            keys_s1_q <= keys;
            keys_s2_q <= keys_s1_q;
            enca_s1_q <= encA;
            enca_s2_q <= enca_s1_q;
            encb_s1_q <= encB;
            encb_s2_q <= encb_s1_q;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        ch_sample            = '0;
        ch_sample[KEY_N-1:0] = (KEY_ACT_LOW != 0) ? ~keys_s2_q : keys_s2_q;
        for (int e = 0; e < ENC_N; e++) begin
            ch_sample[KEY_N + 2*e]     = enca_s2_q[e];
            ch_sample[KEY_N + 2*e + 1] = encb_s2_q[e];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: if (scanTick) begin
                state_d = ST_SCAN;
                ptr_d   = '0;
            end
            ST_SCAN: begin
                if (ptr_q == LAST_CH) state_d = ST_IDLE;
                else                  ptr_d   = ptr_q + PTR_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign scan_active = (state_q == ST_SCAN);

    // Counter stops at its maximum instead of wrapping if DEB_TICKS were ever out of range.
    always_comb begin
        deb_bit_d = deb_q[ptr_q];
        cnt_d     = '0;
        changed   = 1'b0;
        if (ch_sample[ptr_q] != deb_q[ptr_q]) begin
            if (cnt_q[ptr_q] >= DEB_LIMIT - 4'd1) begin
                deb_bit_d = ch_sample[ptr_q];
                changed   = 1'b1;
            end else if (cnt_q[ptr_q] != 4'hF) begin
                cnt_d = cnt_q[ptr_q] + 4'd1;
            end else begin
                cnt_d = cnt_q[ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            deb_q <= '0;
            for (int i = 0; i < CH_N; i++) cnt_q[i] <= '0;
        end else if (scan_active) begin
            deb_q[ptr_q] <= deb_bit_d;
            cnt_q[ptr_q] <= cnt_d;
        end
    end

    // Encoder direction comes from the already-debounced B of the same encoder.
    assign enc_off = ptr_q - FIRST_ENC;
    assign is_key  = (ptr_q < FIRST_ENC);
    assign b_dbn   = deb_q[ptr_q + PTR_W'(1)];
    assign ev_push = scan_active & changed & (is_key | (~enc_off[0] & ~deb_bit_d));
    assign ev_code = is_key ? make_event(1'b0, deb_bit_d, EV_IDX_W'(ptr_q))
                            : make_event(1'b1, b_dbn, EV_IDX_W'(enc_off >> 1));

    event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_push),
        .din   (EVENT_W'(ev_code)),
        .pop   (evRead),
        .clr   (fifoClr),
        .dout  (evData),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (evCount)
    );

    always_ff @(posedge clk) begin
        if (!rst)                                  overflow_q <= 1'b0;
        else if (fifoClr)                          overflow_q <= 1'b0;
        else if (ev_push && fifo_full && !evRead)  overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
    assign evValid  = ~fifo_empty;
    assign scanBusy = scan_active;

endmodule

// File: tb/tb_key_event_scanner.sv
// Directed bench for key_event_scanner: debounce, encoder decode, FIFO limits
// and mid-pass reset, with hand-computed event codes.
module tb_key_event_scanner;

    localparam int KEY_N = 32;
    localparam int ENC_N = 4;
    localparam int CH_N  = KEY_N + 2 * ENC_N;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             scanTick = 1'b0;
    logic             evRead   = 1'b0;
    logic             fifoClr  = 1'b0;
    logic [KEY_N-1:0] keys     = '1;
    logic [ENC_N-1:0] encA     = '0;
    logic [ENC_N-1:0] encB     = '0;
    logic [7:0]       evData;
    logic             evValid;
    logic [4:0]       evCount;
    logic             overflow;
    logic             scanBusy;

    int n_checks = 0;
    int n_fail   = 0;

    key_event_scanner dut (
        .clk      (clk),
        .rst      (rst),
        .scanTick (scanTick),
        .keys     (keys),
        .encA     (encA),
        .encB     (encB),
        .evRead   (evRead),
        .fifoClr  (fifoClr),
        .evData   (evData),
        .evValid  (evValid),
        .evCount  (evCount),
        .overflow (overflow),
        .scanBusy (scanBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic run_pass();
        @(negedge clk) scanTick = 1'b1;
        @(negedge clk) scanTick = 1'b0;
        repeat (CH_N + 1) @(negedge clk);
    endtask

    task automatic run_passes(input int n);
        for (int i = 0; i < n; i++) run_pass();
    endtask

    task automatic pop_one();
        @(negedge clk) evRead = 1'b1;
        @(negedge clk) evRead = 1'b0;
    endtask

    initial begin
        // Reset with all keys idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_evValid",  32'(evValid),  32'h0);
        check("rst_evCount",  32'(evCount),  32'h0);
        check("rst_evData",   32'(evData),   32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_scanBusy", 32'(scanBusy), 32'h0);

        // Press key 5 and hold for four passes
        keys[5] = 1'b0;
        settle();
        run_passes(3);
        check("k5_after3_count", 32'(evCount), 32'h0);
        @(negedge clk) scanTick = 1'b1;
        @(negedge clk) scanTick = 1'b0;
        check("scanBusy_in_pass", 32'(scanBusy), 32'h1);
        repeat (CH_N + 1) @(negedge clk);
        check("scanBusy_after_pass", 32'(scanBusy), 32'h0);
        check("k5_press_count", 32'(evCount), 32'h1);
        check("k5_press_data",  32'(evData),  32'h45);
        check("k5_press_valid", 32'(evValid), 32'h1);
        run_passes(2);
        check("k5_no_repeat", 32'(evCount), 32'h1);
        pop_one();
        check("k5_popped", 32'(evCount), 32'h0);

        // Release, then bounce: 3 low, 1 high, 4 low, then release
        keys[5] = 1'b1;
        settle();
        run_passes(4);
        check("k5_rel_data", 32'(evData), 32'h05);
        pop_one();
        keys[5] = 1'b0; settle(); run_passes(3);
        keys[5] = 1'b1; settle(); run_pass();
        keys[5] = 1'b0; settle(); run_passes(3);
        check("bounce_no_event", 32'(evCount), 32'h0);
        run_pass();
        check("bounce_count", 32'(evCount), 32'h1);
        check("bounce_data",  32'(evData),  32'h45);
        pop_one();
        keys[5] = 1'b1;
        settle();
        run_passes(4);
        check("bounce_rel_data", 32'(evData), 32'h05);
        pop_one();
        check("bounce_empty", 32'(evCount), 32'h0);

        // Encoder 2: A falls with B=1, then with B=0; B toggles alone
        encA[2] = 1'b1; encB[2] = 1'b1;
        settle(); run_passes(4);
        check("enc_rise_no_event", 32'(evCount), 32'h0);
        encA[2] = 1'b0;
        settle(); run_passes(4);
        check("enc_cw_count", 32'(evCount), 32'h1);
        check("enc_cw_data",  32'(evData),  32'hC2);
        encB[2] = 1'b0;
        settle(); run_passes(4);
        check("enc_b_fall_no_event", 32'(evCount), 32'h1);
        encA[2] = 1'b1; settle(); run_passes(4);
        encA[2] = 1'b0; settle(); run_passes(4);
        check("enc_ccw_count", 32'(evCount), 32'h2);
        pop_one();
        check("enc_ccw_data", 32'(evData), 32'h82);
        pop_one();
        encB[2] = 1'b1; settle(); run_passes(4);
        encB[2] = 1'b0; settle(); run_passes(4);
        check("enc_b_only", 32'(evCount), 32'h0);

        // Fill with 16 key presses, then a 17th is dropped
        keys[15:0] = '0;
        settle(); run_passes(4);
        check("fill_count",    32'(evCount),  32'h10);
        check("fill_overflow", 32'(overflow), 32'h0);
        check("fill_head",     32'(evData),   32'h40);
        keys[16] = 1'b0;
        settle(); run_passes(4);
        check("drop_count",    32'(evCount),  32'h10);
        check("drop_overflow", 32'(overflow), 32'h1);
        check("drop_head",     32'(evData),   32'h40);
        @(negedge clk) fifoClr = 1'b1;
        @(negedge clk) fifoClr = 1'b0;
        check("clr_count",    32'(evCount),  32'h0);
        check("clr_overflow", 32'(overflow), 32'h0);
        check("clr_valid",    32'(evValid),  32'h0);
        pop_one();
        check("empty_read_count", 32'(evCount), 32'h0);
        check("empty_read_data",  32'(evData),  32'h0);

        // Full FIFO: push and read in the same clock
        keys[15:0] = '1;
        settle(); run_passes(4);
        check("full2_count", 32'(evCount), 32'h10);
        check("full2_head",  32'(evData),  32'h00);
        keys[16] = 1'b1;
        settle(); run_passes(3);
        @(negedge clk) scanTick = 1'b1;
        @(negedge clk) scanTick = 1'b0;
        repeat (16) @(negedge clk);
        evRead = 1'b1;
        @(negedge clk) evRead = 1'b0;
        repeat (CH_N + 1 - 17) @(negedge clk);
        check("pushpop_count",    32'(evCount),  32'h10);
        check("pushpop_overflow", 32'(overflow), 32'h0);
        check("pushpop_head",     32'(evData),   32'h01);

        // Reset mid-pass at ptr=10 with key 12 one pass from accepted
        @(negedge clk) fifoClr = 1'b1;
        @(negedge clk) fifoClr = 1'b0;
        keys[12] = 1'b0;
        settle(); run_passes(3);
        check("pre_rst_count", 32'(evCount), 32'h0);
        @(negedge clk) scanTick = 1'b1;
        @(negedge clk) scanTick = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        check("midrst_scanBusy", 32'(scanBusy), 32'h0);
        check("midrst_count",    32'(evCount),  32'h0);
        check("midrst_valid",    32'(evValid),  32'h0);
        check("midrst_data",     32'(evData),   32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        repeat (5) @(negedge clk);
        run_passes(3);
        check("midrst_3pass", 32'(evCount), 32'h0);
        run_pass();
        check("midrst_4pass_count", 32'(evCount), 32'h1);
        check("midrst_4pass_data",  32'(evData),  32'h4C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
